// File: rtl/imm_pack_if.sv
// imm_pack_if: request/response bundle for imm_pack.
//   request : in_valid/in_ready handshake carrying imm_sel, imm, inst_in
//   response: out_valid/out_ready handshake carrying inst_out, out_err
// master = producer of requests / consumer of packed words, slave = imm_pack.
interface imm_pack_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  imm_sel;
  logic [31:0] imm;
  logic [31:0] inst_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] inst_out;
  logic [2:0]  out_err;

  modport master (
    output in_valid, imm_sel, imm, inst_in, out_ready,
    input  in_ready, out_valid, inst_out, out_err
  );

  modport slave (
    input  in_valid, imm_sel, imm, inst_in, out_ready,
    output in_ready, out_valid, inst_out, out_err
  );
endinterface

// File: rtl/imm_pack.sv
// imm_pack: inverse immediate generator. Scatters a signed immediate into the
// instruction-field positions chosen by imm_sel, keeping every other bit from
// the template, and flags range / alignment / select errors. Packed words are
// queued in a DEPTH-entry FIFO.
// Ports:
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   io          imm_pack_if.slave: request in, packed word + {sel,align,range} out
//   err_cnt     saturating count of accepted requests carrying any error
//   clr_cnt     synchronous clear of err_cnt (wins over a same-cycle increment)
module imm_pack #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  imm_pack_if.slave        io,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             clr_cnt
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] inst;
    logic [2:0]  err;   // {sel_err, align_err, range_err}
  } ent_t;

  // ---------------- packing (combinational at accept) ----------------
  logic signed [31:0] s_imm;
  logic [31:0]        pk_inst;
  logic               rng_e, aln_e, sel_e;

  assign s_imm = signed'(io.imm);

  always_comb begin
    pk_inst = io.inst_in;
    rng_e   = 1'b0;
    aln_e   = 1'b0;
    sel_e   = 1'b0;
    case (io.imm_sel)
      3'b000, 3'b001, 3'b011: begin  // I-type / load / jalr
        pk_inst[31:20] = io.imm[11:0];
        rng_e = (s_imm < -32'sd2048) || (s_imm > 32'sd2047);
      end
      3'b010: begin                  // store
        pk_inst[31:25] = io.imm[11:5];
        pk_inst[11:7]  = io.imm[4:0];
        rng_e = (s_imm < -32'sd2048) || (s_imm > 32'sd2047);
      end
      3'b110: begin                  // branch, byte offset, bit 0 dropped
        pk_inst[31]    = io.imm[12];
        pk_inst[30:25] = io.imm[10:5];
        pk_inst[11:8]  = io.imm[4:1];
        pk_inst[7]     = io.imm[11];
        rng_e = (s_imm < -32'sd4096) || (s_imm > 32'sd4094);
        aln_e = io.imm[0];
      end
      3'b100: begin                  // jal, byte offset, bit 0 dropped
        pk_inst[31]    = io.imm[20];
        pk_inst[30:21] = io.imm[10:1];
        pk_inst[20]    = io.imm[11];
        pk_inst[19:12] = io.imm[19:12];
        rng_e = (s_imm < -32'sd1048576) || (s_imm > 32'sd1048574);
        aln_e = io.imm[0];
      end
      default: sel_e = 1'b1;         // 101 / 111: template passes through
    endcase
  end

  ent_t pk;
  assign pk = '{inst: pk_inst, err: {sel_e, aln_e, rng_e}};

  // ---------------- FIFO ----------------
  ent_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          rdy_en;   // holds in_ready low until the first edge after reset
  logic          push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // in_ready depends only on registered state: no path from out_ready.
  assign io.in_ready  = rdy_en && (count < CW'(DEPTH));
  assign io.out_valid = (count != '0);
  assign io.inst_out  = mem[rd_ptr].inst;
  assign io.out_err   = mem[rd_ptr].err;
  assign push = io.in_valid && io.in_ready;
  assign pop  = io.out_valid && io.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (push) begin
        mem[wr_ptr] <= pk;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------- error counter ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt <= '0;
    else if (clr_cnt)
      err_cnt <= '0;
    else if (push && (pk.err != 3'b000) && !(&err_cnt))
      err_cnt <= err_cnt + 1'b1;
  end
endmodule

// File: doc/imm_pack.md
Name: imm_pack

Overview:
- Inverse of the core's immediate generator. Takes an instruction template and a 32-bit signed immediate, and scatters the immediate into the bit positions selected by imm_sel.
- Range-checks and alignment-checks the immediate, and flags bad selects.
- Used by the boot/self-test program builder and the verification stimulus path to emit legal instruction words.
- Valid/ready on both sides, with a small output FIFO.

Parameters:
- DEPTH, 2, output FIFO entries (>=1).
- CNT_W, 16, width of the saturating error counter.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid&in_ready
- imm_sel  input  3  format select, same encoding as immediate generator
- imm  input  32  signed immediate (byte offset for branch/jal)
- inst_in  input  32  template; opcode/rd/rs1/rs2/funct bits
- out_valid  output  1  FIFO head valid
- out_ready  input  1  consumer ready
- inst_out  output  32  packed instruction
- out_err  output  3  {sel_err, align_err, range_err} for inst_out
- err_cnt  output  CNT_W  count of accepted requests with any error
- clr_cnt  input  1  synchronous clear of err_cnt

Behaviour:
- Reset (rst_n low, async):
  - FIFO empty; out_valid=0, inst_out=0, out_err=0, err_cnt=0.
  - in_ready=1 one cycle after release. Pending entries are discarded.
- Encoding, combinational at accept. Bits listed are overwritten by imm; all other bits come from inst_in.
  - 000 ALU I-type / 001 load / 011 jalr: [31:20]=imm[11:0]. range_err if imm not in [-2048,2047].
  - 010 store: [31:25]=imm[11:5], [11:7]=imm[4:0]. Same range rule.
  - 110 branch: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
    - range_err if imm not in [-4096,4094].
    - align_err if imm[0]=1.
  - 100 jal: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
    - range_err if imm not in [-2^20, 2^20-2].
    - align_err if imm[0]=1.
  - 101, 111: inst_out=inst_in unchanged; sel_err=1; range_err=align_err=0.
  - On error the instruction is still packed with truncated bits; errors are flags only.
- Handshake:
  - in_ready = (count < DEPTH). Registered-count based; no combinational path from out_ready.
  - Push on in_valid&in_ready; pop on out_valid&out_ready. Push and pop in the same cycle leave count unchanged.
  - Latency: accepted on edge N, visible at head with out_valid=1 after edge N when the FIFO was empty.
  - inst_out/out_err hold stable while out_valid&!out_ready. Strict FIFO order.
  - Full and popping in the same cycle: no push that cycle (in_ready was 0); in_ready=1 next cycle.
  - in_valid while in_ready=0 is ignored; the source must hold its request.
- err_cnt:
  - Increments by 1 on each accepted request whose error vector is non-zero.
  - Saturates at all-ones.
  - clr_cnt has priority: the count goes to 0 and that cycle's error is not counted.
- The pointers wrap modulo DEPTH. DEPTH not a power of 2 is supported.

Test Plan:
- addi x1,x0,-1: imm_sel=000, imm=0xFFFFFFFF, inst_in=0x00000093 -> inst_out=0xFFF00093, out_err=000, one cycle after accept.
- sw x2,8(x1): sel=010, imm=8, inst_in=0x0020A023 -> 0x0020A423, err=000. beq x0,x0,-4: sel=110, imm=0xFFFFFFFC, inst_in=0x00000063 -> 0xFE000EE3.
- jal ra,+2048: sel=100, imm=0x800, inst_in=0x000000EF -> 0x001000EF. Same with imm=0x801 -> align_err=1, err_cnt +1.
- Errors:
  - sel=000 imm=0x800 -> range_err=1, inst_out[31:20]=0x800.
  - sel=111 -> sel_err=1, inst_out=inst_in.
  - clr_cnt with a simultaneous erroneous accept -> err_cnt=0.
- Backpressure (DEPTH=2): out_ready=0, push 3 back-to-back -> in_ready low after 2 accepts. Raise out_ready -> outputs in order, third accepted the cycle after the first pop. Simultaneous push/pop at count=1 keeps out_valid high.
- Assert rst_n low with 2 entries queued -> out_valid=0, err_cnt=0 immediately (async). After release, the first new request emerges with no stale data.
